// File: rtl/centroid_overlay_if.sv
// Video stream and centroid coordinate bundle for centroid_overlay.
// The master drives video/coordinates in and receives the overlaid stream out.
interface centroid_overlay_if;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [23:0] pixel_in;
  logic [11:0] x_c;
  logic [11:0] y_c;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [23:0] pixel_out;
  logic        marker_on;

  modport master (
    output de_in, hsync_in, vsync_in, pixel_in, x_c, y_c,
    input  de_out, hsync_out, vsync_out, pixel_out, marker_on
  );

  modport slave (
    input  de_in, hsync_in, vsync_in, pixel_in, x_c, y_c,
    output de_out, hsync_out, vsync_out, pixel_out, marker_on
  );
endinterface

// File: rtl/centroid_overlay.sv
// Draws a crosshair at the centroid latched on each vsync rising edge,
// passing the video stream through with a fixed 2-cycle latency.
module centroid_overlay #(
  parameter int          IMG_H = 64,
  parameter int          IMG_W = 64,
  parameter int          ARM   = 3,
  parameter logic [23:0] COLOR = 24'hFF0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              en,
  centroid_overlay_if.slave vid
);

  localparam logic [11:0] COL_LAST  = 12'(IMG_W - 1);
  localparam logic [11:0] LINE_LAST = 12'(IMG_H - 1);
  localparam logic [11:0] H_LIM     = 12'(IMG_H);
  localparam logic [11:0] W_LIM     = 12'(IMG_W);
  localparam logic [12:0] ARM_L     = 13'(ARM);

  logic [11:0] col_q, col_d, line_q, line_d;
  logic [11:0] xl_q, yl_q;
  logic        enl_q, vs_prev_q, valid_q;
  logic        hit_s1_q, de_s1_q, hs_s1_q, vs_s1_q;
  logic [23:0] pix_s1_q;
  logic        de_o_q, hs_o_q, vs_o_q;
  logic [23:0] pix_o_q;

  logic signed [12:0] dc, dl;
  logic        [12:0] adc, adl;
  logic               hit_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (vid.vsync_in) begin
      col_d  = '0;
      line_d = '0;
    end else if (vid.de_in) begin
      if (col_q == COL_LAST) begin
        col_d  = '0;
        line_d = (line_q == LINE_LAST) ? '0 : line_q + 12'd1;
      end else begin
        col_d = col_q + 12'd1;
      end
    end
  end

  // Signed differences so arms stop at the image border instead of wrapping.
  always_comb begin
    dc    = $signed({1'b0, col_q}) - $signed({1'b0, yl_q});
    dl    = $signed({1'b0, line_q}) - $signed({1'b0, xl_q});
    adc   = dc[12] ? 13'(-dc) : 13'(dc);
    adl   = dl[12] ? 13'(-dl) : 13'(dl);
    hit_d = valid_q && vid.de_in && !vid.vsync_in &&
            (((line_q == xl_q) && (adc <= ARM_L)) ||
             ((col_q == yl_q) && (adl <= ARM_L)));
  end

  // NOTE: reset is asynchronous and active-low; all state, including the
  // pipeline, clears immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q     <= '0;
      line_q    <= '0;
      xl_q      <= '0;
      yl_q      <= '0;
      enl_q     <= 1'b0;
      vs_prev_q <= 1'b0;
      valid_q   <= 1'b0;
      hit_s1_q  <= 1'b0;
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      pix_s1_q  <= '0;
      de_o_q    <= 1'b0;
      hs_o_q    <= 1'b0;
      vs_o_q    <= 1'b0;
      pix_o_q   <= '0;
    end else if (ce) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      col_q     <= col_d;
      line_q    <= line_d;
      vs_prev_q <= vid.vsync_in;
      if (vid.vsync_in && !vs_prev_q) begin
        xl_q  <= vid.x_c;
        yl_q  <= vid.y_c;
        enl_q <= en;
      end
      valid_q  <= enl_q && (xl_q < H_LIM) && (yl_q < W_LIM);
      hit_s1_q <= hit_d;
      de_s1_q  <= vid.de_in;
      hs_s1_q  <= vid.hsync_in;
      vs_s1_q  <= vid.vsync_in;
      pix_s1_q <= vid.pixel_in;
      de_o_q   <= de_s1_q;
      hs_o_q   <= hs_s1_q;
      vs_o_q   <= vs_s1_q;
      pix_o_q  <= hit_s1_q ? COLOR : pix_s1_q;
    end
  end

  assign vid.de_out    = de_o_q;
  assign vid.hsync_out = hs_o_q;
  assign vid.vsync_out = vs_o_q;
  assign vid.pixel_out = pix_o_q;
  assign vid.marker_on = valid_q;

endmodule

// File: tb/tb_centroid_overlay.sv
// Self-checking bench for centroid_overlay: frame-level reference model of the
// crosshair geometry, per-pixel output comparison and per-frame marker counts.
module tb_centroid_overlay;

  localparam int          IMG_H = 64;
  localparam int          IMG_W = 64;
  localparam int          ARM   = 3;
  localparam logic [23:0] COLOR = 24'hFF0000;

  logic clk, rst, ce, en;
  centroid_overlay_if vid ();

  centroid_overlay #(
    .IMG_H(IMG_H), .IMG_W(IMG_W), .ARM(ARM), .COLOR(COLOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .en (en),
    .vid(vid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
    logic        valid;
  } exp_t;

  exp_t exp_s1, exp_s2;
  int   m_xl, m_yl;
  bit   m_enl, m_prev_vs;
  int   n_cmp, n_err, n_print;
  int   obs_hits, model_hits;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [23:0] rpix();
    return 24'($urandom) | 24'h000001;
  endfunction

  task automatic report(input string name, input logic [31:0] got, input logic [31:0] want);
    n_err++;
    if (n_print < 40) begin
      n_print++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_s1    = '0;
    exp_s2    = '0;
    m_xl      = 0;
    m_yl      = 0;
    m_enl     = 1'b0;
    m_prev_vs = 1'b0;
  endtask

  // One clock of stimulus; line/col are the true position of an active pixel.
  task automatic drive_cycle(input bit de, input bit hs, input bit vs,
                             input logic [23:0] pix, input bit ce_v,
                             input int line, input int col);
    bit valid, hit;
    vid.de_in    = de;
    vid.hsync_in = hs;
    vid.vsync_in = vs;
    vid.pixel_in = pix;
    ce           = ce_v;
    @(posedge clk);
    if (ce_v && rst) begin
      valid = m_enl && (m_xl < IMG_H) && (m_yl < IMG_W);
      hit   = valid && de && !vs &&
              ((line == m_xl && iabs(col - m_yl) <= ARM) ||
               (col == m_yl && iabs(line - m_xl) <= ARM));
      if (hit) model_hits++;
      exp_s2 = exp_s1;
      exp_s1 = '{de: de, hs: hs, vs: vs, pix: (hit ? COLOR : pix), valid: valid};
      if (vs && !m_prev_vs) begin
        m_xl  = int'(vid.x_c);
        m_yl  = int'(vid.y_c);
        m_enl = en;
      end
      m_prev_vs = vs;
    end
    @(negedge clk);
    n_cmp += 4;
    if (vid.de_out !== exp_s2.de)     report("de_out", 32'(vid.de_out), 32'(exp_s2.de));
    if (vid.hsync_out !== exp_s2.hs)  report("hsync_out", 32'(vid.hsync_out), 32'(exp_s2.hs));
    if (vid.vsync_out !== exp_s2.vs)  report("vsync_out", 32'(vid.vsync_out), 32'(exp_s2.vs));
    if (vid.pixel_out !== exp_s2.pix) report("pixel_out", 32'(vid.pixel_out), 32'(exp_s2.pix));
    if (exp_s2.de) begin
      n_cmp++;
      if (vid.marker_on !== exp_s2.valid) report("marker_on", 32'(vid.marker_on), 32'(exp_s2.valid));
    end
    if (ce_v && vid.de_out === 1'b1 && vid.pixel_out === COLOR) obs_hits++;
  endtask

  task automatic async_reset_pulse();
    #2;
    rst = 1'b0;
    #1;
    n_cmp += 5;
    if (vid.de_out !== 1'b0)     report("async_rst_de", 32'(vid.de_out), 0);
    if (vid.hsync_out !== 1'b0)  report("async_rst_hs", 32'(vid.hsync_out), 0);
    if (vid.vsync_out !== 1'b0)  report("async_rst_vs", 32'(vid.vsync_out), 0);
    if (vid.pixel_out !== 24'h0) report("async_rst_pix", 32'(vid.pixel_out), 0);
    if (vid.marker_on !== 1'b0)  report("async_rst_marker", 32'(vid.marker_on), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_frame(input int xc, input int yc, input bit en_v,
                           input int chg_line, input int chg_xc,
                           input int ce_line, input int rst_line);
    vid.x_c = 12'(xc);
    vid.y_c = 12'(yc);
    en      = en_v;
    repeat (2) drive_cycle(0, 0, 1, rpix(), 1, 0, 0);
    repeat (3) drive_cycle(0, 0, 0, rpix(), 1, 0, 0);
    for (int line = 0; line < IMG_H; line++) begin
      if (line == chg_line) vid.x_c = 12'(chg_xc);
      for (int col = 0; col < IMG_W; col++) begin
        if (line == ce_line && col == 20)
          repeat (5) drive_cycle(1, 0, 0, rpix(), 0, line, col);
        if (line == rst_line && col == 30) async_reset_pulse();
        drive_cycle(1, 0, 0, rpix(), 1, line, col);
      end
      repeat (2) drive_cycle(0, 1, 0, rpix(), 1, 0, 0);
      repeat (2) drive_cycle(0, 0, 0, rpix(), 1, 0, 0);
    end
    repeat (3) drive_cycle(0, 0, 0, rpix(), 1, 0, 0);
  endtask

  task automatic check_count(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) report(name, 32'(got), 32'(want));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ce  = 1'b1;
    en  = 1'b1;
    vid.x_c = 12'd10;
    vid.y_c = 12'd20;
    for (int i = 0; i < 4; i++) begin
      vid.de_in    = i[0];
      vid.vsync_in = i[1];
      vid.hsync_in = i[0];
      vid.pixel_in = rpix();
      @(posedge clk);
      @(negedge clk);
      n_cmp += 5;
      if (vid.de_out !== 1'b0)     report("rst_de", 32'(vid.de_out), 0);
      if (vid.hsync_out !== 1'b0)  report("rst_hs", 32'(vid.hsync_out), 0);
      if (vid.vsync_out !== 1'b0)  report("rst_vs", 32'(vid.vsync_out), 0);
      if (vid.pixel_out !== 24'h0) report("rst_pix", 32'(vid.pixel_out), 0);
      if (vid.marker_on !== 1'b0)  report("rst_marker", 32'(vid.marker_on), 0);
    end
    vid.vsync_in = 1'b0;
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(i % 2 == 0, 0, 0, 24'h123456, 1, 0, i);
      n_cmp++;
      if (vid.marker_on !== 1'b0) report("idle_marker_on", 32'(vid.marker_on), 0);
    end
  endtask

  task automatic test_marker_draw();
    int h0 = obs_hits;
    run_frame(10, 20, 1, -1, 0, -1, -1);
    check_count("draw_count", obs_hits - h0, 13);
  endtask

  task automatic test_mid_frame();
    int h0 = obs_hits;
    run_frame(10, 20, 1, 30, 40, -1, -1);
    check_count("midframe_n_count", obs_hits - h0, 13);
    h0 = obs_hits;
    run_frame(40, 20, 1, -1, 0, -1, -1);
    check_count("midframe_n1_count", obs_hits - h0, 13);
  endtask

  task automatic test_clip();
    int h0 = obs_hits;
    run_frame(0, 0, 1, -1, 0, -1, -1);
    check_count("clip_00_count", obs_hits - h0, 7);
    n_cmp++;
    if (vid.marker_on !== 1'b1) report("clip_00_marker_on", 32'(vid.marker_on), 1);
    h0 = obs_hits;
    run_frame(64, 5, 1, -1, 0, -1, -1);
    check_count("range_64_count", obs_hits - h0, 0);
    n_cmp++;
    if (vid.marker_on !== 1'b0) report("range_64_marker_on", 32'(vid.marker_on), 0);
  endtask

  task automatic test_ce_hold();
    int h0 = obs_hits;
    run_frame(10, 20, 1, -1, 0, 10, -1);
    check_count("ce_hold_count", obs_hits - h0, 13);
  endtask

  task automatic test_async_reset();
    int h0 = obs_hits;
    run_frame(10, 20, 1, -1, 0, -1, 10);
    check_count("async_rst_frame_count", obs_hits - h0, 10);
    h0 = obs_hits;
    run_frame(10, 20, 1, -1, 0, -1, -1);
    check_count("async_rst_next_count", obs_hits - h0, 13);
  endtask

  task automatic test_en_off();
    int h0 = obs_hits;
    run_frame(10, 20, 0, -1, 0, -1, -1);
    check_count("en_off_count", obs_hits - h0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      int h0 = obs_hits;
      int m0 = model_hits;
      run_frame(int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
                bit'($urandom_range(0, 3) != 0), -1, 0, -1, -1);
      check_count("random_count", obs_hits - h0, model_hits - m0);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_print = 0; obs_hits = 0; model_hits = 0;
    ce = 1'b1; en = 1'b0; rst = 1'b0;
    vid.de_in = 1'b0; vid.hsync_in = 1'b0; vid.vsync_in = 1'b0;
    vid.pixel_in = '0; vid.x_c = '0; vid.y_c = '0;
    model_reset();
    test_reset();
    test_marker_draw();
    test_mid_frame();
    test_clip();
    test_ce_hold();
    test_async_reset();
    test_en_off();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/centroid_overlay.md
Name: centroid_overlay

Overview:
- Consumes the (x, y) coordinates produced by the centroid stage and the matching video stream, and draws a crosshair marker at that position.
- Sits after centroid in the video pipeline and feeds the output video path.
- Coordinates are sampled once per frame at the vsync rising edge, so the marker never tears mid-frame.
- The video stream is passed through with a fixed 2-cycle latency; syncs and pixels stay aligned.

Parameters:
- IMG_H, 64, number of active lines per frame (line index range 0..IMG_H-1).
- IMG_W, 64, number of active pixels per line (column index range 0..IMG_W-1).
- ARM, 3, crosshair half-length in pixels; total arm length is 2*ARM+1.
- COLOR, 24'hFF0000, RGB value written on marker pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; 0 freezes every register.
- en  in  1  marker enable; 0 gives pure passthrough (still 2-cycle latency).
- de_in  in  1  data enable of input video.
- hsync_in  in  1  input hsync.
- vsync_in  in  1  input vsync.
- pixel_in  in  24  input RGB pixel.
- x_c  in  12  centroid line index (row).
- y_c  in  12  centroid column index.
- de_out  out  1  de_in delayed 2 cycles.
- hsync_out  out  1  hsync_in delayed 2 cycles.
- vsync_out  out  1  vsync_in delayed 2 cycles.
- pixel_out  out  24  pixel_in delayed 2 cycles, or COLOR on a marker hit.
- marker_on  out  1  1 while the latched coordinates are valid and en is latched 1 for the current frame.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; line/column counters 0; latched coordinates 0; latched en 0; vsync edge register 0. Takes effect immediately, including mid-frame. After release, no marker is drawn until the next vsync rising edge.
- ce=0: no register changes, including counters, pipeline and latches. Outputs hold their values.
- Position counters (ce=1):
  - vsync_in=1 clears col and line.
  - Else on de_in=1, col increments.
  - When col==IMG_W-1 and de_in=1: col goes to 0 and line increments.
  - When line==IMG_H-1 and col==IMG_W-1 and de_in=1: line goes to 0.
  - Counters are 12 bits.
- Frame latch: on vsync_in=1 with the previous vsync_in=0, capture x_c→xl, y_c→yl and en→enl.
  - valid = enl && xl<IMG_H && yl<IMG_W. valid drives marker_on (registered, updated the cycle after the latch).
  - Changes on x_c/y_c/en between vsync edges have no effect on the current frame.
- Hit test, computed from the counters of the current input pixel:
  - hit = valid && de_in && ((line==xl && |col-yl|<=ARM) || (col==yl && |line-xl|<=ARM)).
  - Differences are computed as 13-bit signed, then absolute value.
  - The centre pixel counts once.
  - Arms clip naturally at image borders; there is no wrap to the opposite edge.
- Pipeline:
  - Stage 1 registers hit, pixel_in and the syncs.
  - Stage 2 registers pixel_out = hit ? COLOR : pixel.
  - The delayed syncs/de are output from stage 2.
  - Latency is exactly 2 ce-qualified cycles for all outputs.
- Blanking: pixels with de_in=0 pass through unchanged and are never hits.
- Simultaneous events: vsync_in=1 together with de_in=1 resolves as vsync (counters clear; no hit).

Test Plan:
- Reset/idle:
  - Stimulus: rst=0 then release; no vsync edge; de pulses with pixel_in=0x123456.
  - Required: all outputs 0 during reset. After release, pixel_out=0x123456 two cycles after each input and marker_on=0.
- Marker draw:
  - Stimulus: IMG 64x64, ARM=3, en=1, x_c=10, y_c=20, pixel_in=0 over a full frame.
  - Required: exactly 13 pixels equal 0xFF0000 (line 10 cols 17..23; col 20 lines 7..13); all others 0. Each output appears 2 cycles after its input.
- Mid-frame change:
  - Stimulus: change x_c to 40 at line 30 of frame N.
  - Required: frame N marker stays at line 10; frame N+1 marker is at line 40.
- Edge clipping and range:
  - Stimulus: x_c=0, y_c=0. Separately, x_c=64, y_c=5.
  - Required: (0,0) gives 7 marker pixels (line 0 cols 0..3, col 0 lines 0..3). (64,5) gives marker_on=0 and no marker pixels.
- ce hold:
  - Stimulus: ce=0 for 5 cycles mid-line.
  - Required: outputs and counters frozen. After resume, the marker position and pixel count are unchanged (13 pixels).
- Async reset mid-frame:
  - Stimulus: assert rst=0 between clock edges at line 10.
  - Required: outputs go to 0 without waiting for a clock edge. No marker is drawn until after the next vsync rising edge.
